// File: rtl/mpa_debug_sequencer.sv
`default_nettype none
// ============================================================================
// mpa_debug_sequencer : command-driven burst read/write/run engine for the
//                       mpa_mips_32 debug port.   Rev 1.0
// ============================================================================
module mpa_debug_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int IM_CAPACITY   = 32,
  parameter int DM_CAPACITY   = 32,
  parameter int MR_CAPACITY   = 32,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                     CLK,
  input  logic                     HW_RSTn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [1:0]               cmd_target,
  input  logic [ADDRESS_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     done,
  output logic                     err,
  output logic                     dbg_mem_debug,
  output logic [1:0]               dbg_func,
  output logic                     dbg_we,
  output logic                     dbg_re,
  output logic [ADDRESS_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]    dbg_din,
  input  logic [DATA_WIDTH-1:0]    dbg_dout
);

  localparam int SUM_W = ADDRESS_WIDTH + LEN_WIDTH + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_WR      = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_RD_HOLD = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  logic [2:0]               r_state;
  logic [1:0]               r_target;
  logic [ADDRESS_WIDTH-1:0] r_index;
  logic [LEN_WIDTH-1:0]     r_remain;
  logic [DATA_WIDTH-1:0]    r_rd_data;
  logic                     r_rd_valid;
  logic                     r_done;
  logic                     r_err;
  logic                     r_mem_debug;
  logic [1:0]               r_func;
  logic                     r_we;
  logic                     r_re;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_din;

  logic [SUM_W-1:0]         w_end;
  logic [SUM_W-1:0]         w_cap;
  logic                     w_cmd_bad;
  logic                     w_wr_fire;
  logic [ADDRESS_WIDTH-1:0] w_next_index;

  // IM/DM are byte addressed on the port, the register file is word addressed
  function automatic logic [ADDRESS_WIDTH-1:0] f_port_addr(
    input logic [1:0]               tgt,
    input logic [ADDRESS_WIDTH-1:0] idx
  );
    return (tgt == 2'd3) ? idx : (idx << 2);
  endfunction

  // Wide enough that base+len can never wrap before the capacity compare
  assign w_end = SUM_W'(cmd_base) + SUM_W'(cmd_len);

  always_comb begin
    w_cap = '0;
    case (cmd_target)
      2'd1:    w_cap = SUM_W'(IM_CAPACITY);
      2'd2:    w_cap = SUM_W'(DM_CAPACITY);
      2'd3:    w_cap = SUM_W'(MR_CAPACITY);
      default: w_cap = '0;
    endcase
  end

  assign w_cmd_bad = (cmd_op == OP_RSVD) ||
                     ((cmd_op != OP_RUN) && ((cmd_target == 2'd0) || (w_end > w_cap)));

  assign cmd_ready    = (r_state == S_IDLE);
  assign wr_ready     = (r_state == S_WR) && (r_remain != '0);
  assign w_wr_fire    = wr_valid && wr_ready;
  assign w_next_index = r_index + 1'b1;

  always_ff @(posedge CLK) begin
    if (!HW_RSTn) begin
      r_state     <= S_IDLE;
      r_target    <= 2'd0;
      r_index     <= '0;
      r_remain    <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_debug <= 1'b1;
      r_func      <= 2'd0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_target <= cmd_target;
            r_index  <= cmd_base;
            r_remain <= cmd_len;
            if (w_cmd_bad) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else if (cmd_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (cmd_op == OP_RUN) begin
              r_state     <= S_RUN;
              r_mem_debug <= 1'b0;
              r_func      <= 2'd0;
            end else if (cmd_op == OP_WRITE) begin
              r_state <= S_WR;
              r_func  <= cmd_target;
            end else begin
              r_state <= S_RD_REQ;
              r_func  <= cmd_target;
              r_re    <= 1'b1;
              r_addr  <= f_port_addr(cmd_target, cmd_base);
            end
          end
        end
        S_RUN: begin
          if (r_remain == LEN_WIDTH'(1)) begin
            r_mem_debug <= 1'b1;
            r_state     <= S_DONE;
            r_done      <= 1'b1;
          end else begin
            r_remain <= r_remain - 1'b1;
          end
        end
        S_WR: begin
          r_we <= w_wr_fire;
          if (w_wr_fire) begin
            r_addr   <= f_port_addr(r_target, r_index);
            r_din    <= wr_data;
            r_index  <= w_next_index;
            r_remain <= r_remain - 1'b1;
          end
          // One drain cycle after the last handshake lets its strobe land before done
          if (r_remain == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_RD_REQ: begin
          r_re    <= 1'b0;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          r_rd_data  <= dbg_dout;
          r_rd_valid <= 1'b1;
          r_state    <= S_RD_HOLD;
        end
        S_RD_HOLD: begin
          if (rd_ready) begin
            r_rd_valid <= 1'b0;
            r_index    <= w_next_index;
            r_remain   <= r_remain - 1'b1;
            if (r_remain == LEN_WIDTH'(1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RD_REQ;
              r_re    <= 1'b1;
              r_addr  <= f_port_addr(r_target, w_next_index);
            end
          end
        end
        S_DONE, S_ERR: begin
          r_func  <= 2'd0;
          r_we    <= 1'b0;
          r_re    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign done          = r_done;
  assign err           = r_err;
  assign dbg_mem_debug = r_mem_debug;
  assign dbg_func      = r_func;
  assign dbg_we        = r_we;
  assign dbg_re        = r_re;
  assign dbg_addr      = r_addr;
  assign dbg_din       = r_din;

endmodule
`default_nettype wire

// File: tb/tb_mpa_debug_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mpa_debug_sequencer : directed bench with a small debug-port memory model.
// Rev 1.0
// ============================================================================
module tb_mpa_debug_sequencer;

  logic        CLK = 1'b0;
  logic        HW_RSTn;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op, cmd_target;
  logic [31:0] cmd_base;
  logic [15:0] cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready;
  logic        done, err;
  logic        dbg_mem_debug;
  logic [1:0]  dbg_func;
  logic        dbg_we, dbg_re;
  logic [31:0] dbg_addr, dbg_din;
  logic [31:0] dbg_dout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  mpa_debug_sequencer dut (
    .CLK(CLK), .HW_RSTn(HW_RSTn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_target(cmd_target), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .err(err),
    .dbg_mem_debug(dbg_mem_debug), .dbg_func(dbg_func), .dbg_we(dbg_we),
    .dbg_re(dbg_re), .dbg_addr(dbg_addr), .dbg_din(dbg_din), .dbg_dout(dbg_dout)
  );

  // Core debug-port model: synchronous write, registered read data
  logic [31:0] im [32];
  logic [31:0] dm [32];
  logic [31:0] mr [32];

  always @(posedge CLK) begin
    if (dbg_we) begin
      case (dbg_func)
        2'd1:    im[dbg_addr[6:2]] <= dbg_din;
        2'd2:    dm[dbg_addr[6:2]] <= dbg_din;
        2'd3:    mr[dbg_addr[4:0]] <= dbg_din;
        default: ;
      endcase
    end
    if (dbg_re) begin
      case (dbg_func)
        2'd1:    dbg_dout <= im[dbg_addr[6:2]];
        2'd2:    dbg_dout <= dm[dbg_addr[6:2]];
        2'd3:    dbg_dout <= mr[dbg_addr[4:0]];
        default: dbg_dout <= 32'h0;
      endcase
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  tgt;
    logic [31:0] base;
    logic [15:0] len;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    int          exp_re;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] tgt,
                          input logic [31:0] base, input logic [15:0] len);
    chk("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_op     = op;
    cmd_target = tgt;
    cmd_base   = base;
    cmd_len    = len;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] wdata [4];
    int lat, nwe, nre, n;

    // op, tgt, base, len, err?, latency to pulse, dbg_we count, dbg_re count
    vecs[0]  = '{2'd1, 2'd1, 32'd0,  16'd4,  1'b0, 5, 4, 0};
    vecs[1]  = '{2'd1, 2'd2, 32'd30, 16'd3,  1'b1, 0, 0, 0};
    vecs[2]  = '{2'd2, 2'd2, 32'd29, 16'd3,  1'b0, 9, 0, 3};
    vecs[3]  = '{2'd2, 2'd0, 32'd0,  16'd1,  1'b1, 0, 0, 0};
    vecs[4]  = '{2'd1, 2'd1, 32'd0,  16'd0,  1'b0, 0, 0, 0};
    vecs[5]  = '{2'd3, 2'd1, 32'd0,  16'd1,  1'b1, 0, 0, 0};
    vecs[6]  = '{2'd0, 2'd0, 32'd0,  16'd5,  1'b0, 5, 0, 0};
    vecs[7]  = '{2'd0, 2'd2, 32'd0,  16'd0,  1'b0, 0, 0, 0};
    vecs[8]  = '{2'd1, 2'd3, 32'd31, 16'd1,  1'b0, 2, 1, 0};
    vecs[9]  = '{2'd2, 2'd3, 32'd32, 16'd0,  1'b0, 0, 0, 0};
    vecs[10] = '{2'd2, 2'd1, 32'd0,  16'd33, 1'b1, 0, 0, 0};
    vecs[11] = '{2'd2, 2'd3, 32'd31, 16'd2,  1'b1, 0, 0, 0};
    wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33; wdata[3] = 32'h44;

    HW_RSTn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_target = 2'd0;
    cmd_base = 32'd0; cmd_len = 16'd0; wr_data = 32'd0; wr_valid = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    chk("rst_mem_debug", 64'(dbg_mem_debug), 64'd1);
    chk("rst_strobes", {60'd0, dbg_func, dbg_we, dbg_re}, 64'd0);
    chk("rst_addr_din", {dbg_addr, dbg_din}, 64'd0);
    chk("rst_rd", {31'd0, rd_valid, rd_data}, 64'd0);
    chk("rst_pulses", {62'd0, done, err}, 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    HW_RSTn = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hC0DE_0000 + i;
      rd_ready = 1'b1;
      send_cmd(vecs[i].op, vecs[i].tgt, vecs[i].base, vecs[i].len);
      lat = 0; nwe = 0; nre = 0;
      while (!(done || err) && lat < 200) begin
        nwe += int'(dbg_we);
        nre += int'(dbg_re);
        tick();
        lat++;
      end
      chk($sformatf("v%0d_pulse_seen", i), 64'(lat < 200), 64'd1);
      chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_done", i), 64'(done), 64'(!vecs[i].exp_err));
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_we_count", i), 64'(nwe), 64'(vecs[i].exp_we));
      chk($sformatf("v%0d_re_count", i), 64'(nre), 64'(vecs[i].exp_re));
      chk($sformatf("v%0d_strobes_at_pulse", i), {62'd0, dbg_we, dbg_re}, 64'd0);
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      tick();
      chk($sformatf("v%0d_pulse_one_cycle", i), {62'd0, done, err}, 64'd0);
    end

    // Burst write IM base 0 len 4 with per-cycle port checks
    wr_valid = 1'b1;
    wr_data  = wdata[0];
    send_cmd(2'd1, 2'd1, 32'd0, 16'd4);
    chk("bw_no_early_we", 64'(dbg_we), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k < 3) wr_data = wdata[k+1];
      else wr_valid = 1'b0;
      chk($sformatf("bw%0d_we", k), 64'(dbg_we), 64'd1);
      chk($sformatf("bw%0d_addr", k), 64'(dbg_addr), 64'(4 * k));
      chk($sformatf("bw%0d_din", k), 64'(dbg_din), 64'(wdata[k]));
      chk($sformatf("bw%0d_func", k), 64'(dbg_func), 64'd1);
    end
    tick();
    chk("bw_done", {62'd0, done, dbg_we}, 64'd2);
    tick();
    for (int k = 0; k < 4; k++) chk($sformatf("bw_mem%0d", k), 64'(im[k]), 64'(wdata[k]));

    // Preload r5..r7 through the sequencer, then read back with back-pressure
    wr_valid = 1'b1;
    wr_data  = 32'd5;
    send_cmd(2'd1, 2'd3, 32'd5, 16'd3);
    tick(); wr_data = 32'd6;
    tick(); wr_data = 32'd7;
    tick(); wr_valid = 1'b0;
    tick();
    chk("pre_done", 64'(done), 64'd1);
    tick();
    send_cmd(2'd2, 2'd3, 32'd5, 16'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rd%0d_re", k), 64'(dbg_re), 64'd1);
      chk($sformatf("rd%0d_addr", k), 64'(dbg_addr), 64'(5 + k));
      tick();
      chk($sformatf("rd%0d_wait", k), {62'd0, rd_valid, dbg_re}, 64'd0);
      tick();
      chk($sformatf("rd%0d_valid", k), 64'(rd_valid), 64'd1);
      chk($sformatf("rd%0d_data", k), 64'(rd_data), 64'(5 + k));
      tick();
      chk($sformatf("rd%0d_hold", k), {31'd0, rd_valid, rd_data}, {31'd0, 1'b1, 32'(5 + k)});
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      chk($sformatf("rd%0d_consumed", k), 64'(rd_valid), 64'd0);
    end
    chk("rd_done", 64'(done), 64'd1);
    tick();
    chk("rd_cmd_ready", 64'(cmd_ready), 64'd1);

    // Run window of 32 cycles
    send_cmd(2'd0, 2'd0, 32'd0, 16'd32);
    n = 0;
    while (dbg_mem_debug == 1'b0 && n < 100) begin
      n++;
      tick();
    end
    chk("run_low_cycles", 64'(n), 64'd32);
    chk("run_done", {62'd0, done, dbg_mem_debug}, 64'd3);
    tick();
    chk("run_cmd_ready", {62'd0, cmd_ready, done}, 64'd2);

    // Reset in the middle of a write burst
    wr_valid = 1'b1;
    wr_data  = 32'hAA;
    send_cmd(2'd1, 2'd1, 32'd0, 16'd8);
    tick(); tick(); tick();
    chk("mid_we_active", 64'(dbg_we), 64'd1);
    HW_RSTn  = 1'b0;
    wr_valid = 1'b0;
    tick();
    chk("mid_rst_mem_debug", 64'(dbg_mem_debug), 64'd1);
    chk("mid_rst_strobes", {60'd0, dbg_func, dbg_we, dbg_re}, 64'd0);
    chk("mid_rst_addr_din", {dbg_addr, dbg_din}, 64'd0);
    chk("mid_rst_ready", {62'd0, cmd_ready, wr_ready}, 64'd2);
    chk("mid_rst_pulses", {61'd0, done, err, rd_valid}, 64'd0);
    HW_RSTn = 1'b1;
    tick();
    chk("post_rst_pulses", {62'd0, done, err}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mpa_debug_sequencer.md
# mpa_debug_sequencer

Hardware sequencer for the debug port of `mpa_mips_32`. It accepts queued commands over a valid/ready interface and turns them into debug-port transactions:

- burst writes of IM, DM or MR from a write-data stream;
- burst reads of IM, DM or MR into a back-pressured read-data stream;
- run windows that release the core for N cycles.

It sits between a host or bench agent and the core. It replaces hand-sequenced debug accesses with a parametrised engine that checks bounds and supports any memory depth.

## Interface
Parameters:
- DATA_WIDTH, 32, debug data width
- ADDRESS_WIDTH, 32, debug address width
- IM_CAPACITY, 32, IM depth in words (byte addressed on port)
- DM_CAPACITY, 32, DM depth in words (byte addressed on port)
- MR_CAPACITY, 32, register count (word addressed on port)
- LEN_WIDTH, 16, width of burst length / run cycle count

Ports:
- CLK  in  1  clock; all logic on posedge
- HW_RSTn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer idle, can accept a command
- cmd_op  in  2  0 RUN, 1 WRITE, 2 READ, 3 reserved
- cmd_target  in  2  1 IM, 2 DM, 3 MR, 0 illegal (ignored for RUN)
- cmd_base  in  ADDRESS_WIDTH  start word index
- cmd_len  in  LEN_WIDTH  word count, or cycle count for RUN
- wr_data  in  DATA_WIDTH  write stream data
- wr_valid  in  1  write word offered
- wr_ready  out  1  write word accepted
- rd_data  out  DATA_WIDTH  read stream data
- rd_valid  out  1  read word available
- rd_ready  in  1  read word consumed
- done  out  1  one-cycle pulse, command completed
- err  out  1  one-cycle pulse, command rejected
- dbg_mem_debug  out  1  to core mem_debug
- dbg_func  out  2  to core debug_func
- dbg_we  out  1  to core debug_we
- dbg_re  out  1  to core debug_re
- dbg_addr  out  ADDRESS_WIDTH  to core addr
- dbg_din  out  DATA_WIDTH  to core din
- dbg_dout  in  DATA_WIDTH  from core dout

## Operation
- All outputs are registered, except cmd_ready and wr_ready, which are decoded from state.
- **Reset values:**
  - dbg_mem_debug=1 (core held in debug);
  - dbg_func, dbg_we, dbg_re, dbg_addr, dbg_din = 0;
  - rd_valid, done, err = 0; rd_data = 0;
  - state IDLE.
- **Port address formation:**
  - IM and DM: dbg_addr = index*4.
  - MR: dbg_addr = index.
- **States:** IDLE, RUN, WR, RD_REQ, RD_WAIT, RD_HOLD, DONE, ERR.
- **IDLE:**
  - cmd_ready=1 and dbg_mem_debug=1.
  - A command is accepted on cmd_valid&&cmd_ready. Base and len are latched, and the index counter is loaded with base.
- **Rejection (→ ERR):**
  - op=3;
  - WRITE or READ with target=0;
  - base+len > capacity of the target (computed with a LEN_WIDTH+ADDRESS_WIDTH-safe sum).
- **len=0:** for any legal op, go directly to DONE.
- **RUN:**
  - dbg_mem_debug=0 and dbg_func=0 for exactly len cycles, counted by a down-counter.
  - Then dbg_mem_debug returns to 1, and the state moves to DONE.
- **WR:**
  - dbg_func=target; wr_ready=1.
  - Each wr_valid&&wr_ready handshake does the following in the next cycle: dbg_we=1, dbg_addr=index address, dbg_din=word.
  - Index then increments and remaining count decrements.
  - dbg_we is low in any cycle that follows no handshake.
  - The last handshake moves to DONE.
- **RD_REQ:** dbg_re=1 with dbg_addr for one cycle, then RD_WAIT.
- **RD_WAIT:** capture dbg_dout into rd_data, set rd_valid=1, then RD_HOLD.
- **RD_HOLD:**
  - rd_data stays stable while rd_valid=1 and rd_ready=0.
  - On rd_ready, rd_valid clears and index advances. The next state is RD_REQ, or DONE if this was the last word.
- **DONE / ERR:**
  - A one-cycle done or err pulse, with all dbg strobes low, then IDLE.
  - done and err are never high together.
- No new command is accepted outside IDLE. wr_valid is ignored outside WR.
- **Reset mid-operation:** abandons the command. The next cycle shows reset values, cmd_ready=1, and no done or err.

## Timing
- Command accept to first debug strobe: 1 cycle for RUN and READ. For WRITE, 1 cycle after the first write handshake.
- Write throughput: 1 word/cycle with wr_valid held high.
- Read latency: dbg_re in cycle N, dbg_dout sampled at the end of cycle N+1, rd_valid high from cycle N+2.
- Read throughput: at best 1 word per 3 cycles.
- RUN: dbg_mem_debug is low for exactly len consecutive cycles, starting the cycle after accept.
- done asserts the cycle after the last strobe, the last read consumption, or the end of the RUN window.
- err asserts the cycle after accept of an illegal command.

## Test plan
1. **Burst write:** WRITE IM base 0 len 4, data 0x11,0x22,0x33,0x44, wr_valid held high → dbg_we on 4 consecutive cycles, addr 0,4,8,12, dbg_func=1, matching din, then done.
2. **Read with back-pressure:** MR preloaded r5..r7=5,6,7; READ MR base 5 len 3, rd_ready held low 2 cycles per word → dbg_addr 5,6,7, rd_data 5,6,7 each stable until consumed, then done.
3. **Bounds:** WRITE DM base 30 len 3 → err one cycle later, no dbg_we. Then READ DM base 29 len 3 → legal, done.
4. **Run window:** RUN len 32 → dbg_mem_debug low exactly 32 cycles, then high; done; cmd_ready back to 1.
5. **Reset mid-write:** WRITE IM len 8, HW_RSTn low after 3 words → next cycle all outputs at reset values, cmd_ready=1, no done.
6. **Degenerate commands:** READ target 0 → err. WRITE len 0 → done with no strobes. op=3 → err.
